hazard_controller: RTL
======================

# hazard_controller

Pipeline sequencing controller for the 5-stage MIPS core. It shadows the destination registers of instructions in EXE and MEM and detects read-after-write hazards against the instruction in ID. It drives the freeze, bubble and flush controls for the IF/ID and ID/EXE pipeline registers, and holds the whole pipeline while data memory is not ready. It sits beside ID_stage and consumes ID's decoded sources, destination and branch decision.

## Interface
- FORWARD_EN, 0. 1 = forwarding unit present; only load-use hazards stall.
- CNT_W, 32. Width of the performance counters.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (not a bubble)
- src1, src2  in  5  ID source register numbers
- two_src  in  1  instruction reads src2 as a register (R-type, store, BEQ/BNE)
- id_dest  in  5  ID destination register
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- br_taken  in  1  ID branch resolved taken
- mem_ready  in  1  data memory ready; 0 freezes the whole pipeline
- freeze_if_id  out  1  hold PC and IF/ID
- bubble_id_exe  out  1  load a NOP (all control bits 0) into ID/EXE
- flush_if_id  out  1  clear IF/ID to a NOP
- freeze_all  out  1  hold every pipeline register
- state  out  2  FSM state (RUN=0, STALL=1, FREEZE=2)
- stall_cycles, flush_count, freeze_cycles  out  CNT_W  saturating performance counters

## Operation
- Scoreboard: two slots, EXE and MEM. Each slot holds {v, dest, wb_en, mem_r}. Reset value is all zero (empty).
- match(s, slot) = s≠0 & slot.v & slot.wb_en & slot.dest==s. Register $0 never causes a hazard.
- FORWARD_EN=0: hit(s) = match(s, EXE) | match(s, MEM). The register file writes on the falling edge, so the WB stage is never a hazard.
- FORWARD_EN=1: hit(s) = match(s, EXE) & EXE.mem_r.
- hazard = id_valid & (hit(src1) | two_src & hit(src2)).
- br = id_valid & br_taken & ~hazard. A branch whose operands are hazarded is not yet valid.
- Priority: freeze, then hazard, then branch.
  - ~mem_ready: freeze_all=1, freeze_if_id=1, bubble_id_exe=0, flush_if_id=0.
  - hazard: freeze_if_id=1, bubble_id_exe=1.
  - br: flush_if_id=1.
  - Otherwise all control outputs are 0.
- issue = id_valid & ~hazard.
- Scoreboard update at the clock edge, skipped when freeze_all:
  - MEM ← EXE.
  - EXE ← issue ? {1, id_dest, id_wb_en, id_mem_r_en} : empty.
- FSM (registered, reflects the previous cycle's decision):
  - RUN→STALL on hazard; RUN→FREEZE on ~mem_ready.
  - STALL→RUN when no hazard; STALL→FREEZE on ~mem_ready.
  - FREEZE→RUN when mem_ready & ~hazard; FREEZE→STALL when mem_ready & hazard.
- Counters: all saturate at 2^CNT_W−1.
  - stall_cycles +1 per cycle with bubble_id_exe.
  - flush_count +1 per cycle with flush_if_id.
  - freeze_cycles +1 per cycle with freeze_all.
- Reset: while rst=1 all control outputs are forced to 0. Counters, state and scoreboard clear at the edge. A reset mid-stall or mid-freeze discards all in-flight tracking.

## Timing
- freeze_if_id, bubble_id_exe, flush_if_id and freeze_all are combinational from same-cycle inputs and scoreboard. Zero-cycle latency.
- Scoreboard, state and counters update one edge after the causing cycle.
- FORWARD_EN=0, dependent instruction directly behind its producer: 2 stall cycles. One instruction between them: 1 stall cycle. Two between: 0.
- FORWARD_EN=1, load followed directly by a user: exactly 1 stall cycle. ALU producer: 0 stall cycles.
- Branch: exactly 1 flush cycle per taken branch. br_taken held across a freeze yields a single flush, issued on the first unfrozen cycle.
- Freeze spanning a hazard: no bubble is inserted while frozen. The hazard resumes when mem_ready returns, and stall count is unchanged by the freeze.

## Structure
- Package hazard_pkg:
  - state enum: RUN, STALL, FREEZE.
  - slot struct: {v, dest[4:0], wb_en, mem_r}.
  - constant ZERO_REG = 5'd0.
- One sub-module, hazard_scoreboard: the two-slot shift register with its advance/hold control and the match ports.
- FSM, priority logic and counters live in hazard_controller.

## Test plan
- ADD r3 into EXE, then SUB r5,r3,r4 in ID, FORWARD_EN=0 -> bubble_id_exe and freeze_if_id high for 2 cycles, then issue; stall_cycles=2.
- Same sequence with FORWARD_EN=1 and LW r3 as producer -> exactly 1 stall cycle. Same sequence with ADD r3 as producer -> 0 stall cycles.
- Producer writes r0, consumer reads r0 -> no stall.
- BEQ with br_taken=1, no hazard -> flush_if_id high for 1 cycle; flush_count=1; EXE slot receives the branch with wb_en=0.
- mem_ready=0 for 3 cycles during a 2-cycle stall -> freeze_all high for 3 cycles with bubble_id_exe=0; scoreboard held; freeze_cycles=3; stall resumes and stall_cycles=2 total.
- rst asserted mid-stall -> next cycle state=RUN, scoreboard empty, all counters 0, dependent instruction issues immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   state_t : controller FSM encoding (RUN=0, STALL=1, FREEZE=2)
//   slot_t  : one scoreboard entry {v, dest, wb_en, mem_r}
//   ZERO_REG: register $0, which is hard-wired and never a hazard source
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       wb_en;
    logic       mem_r;
  } slot_t;

  localparam logic [4:0] ZERO_REG   = 5'd0;
  localparam slot_t      SLOT_EMPTY = '0;

  // A source register is hazarded by a slot only if that slot holds a real
  // instruction that will write the same, non-zero register.
  function automatic logic slot_match(input logic [4:0] s, input logic v,
                                      input logic wb_en, input logic [4:0] dest);
    return (s != ZERO_REG) && v && wb_en && (dest == s);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ID-stage <-> hazard controller bundle.
//   Decoded ID instruction: id_valid, src1, src2, two_src, id_dest, id_wb_en,
//   id_mem_r_en, br_taken; data memory status: mem_ready.
//   Pipeline controls back to the core: freeze_if_id, bubble_id_exe,
//   flush_if_id, freeze_all.
// master = core side (drives decode info), slave = hazard controller.
interface hazard_controller_if;
  logic       id_valid;
  logic [4:0] src1;
  logic [4:0] src2;
  logic       two_src;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       br_taken;
  logic       mem_ready;
  logic       freeze_if_id;
  logic       bubble_id_exe;
  logic       flush_if_id;
  logic       freeze_all;

  modport master (
    output id_valid, src1, src2, two_src, id_dest, id_wb_en, id_mem_r_en,
           br_taken, mem_ready,
    input  freeze_if_id, bubble_id_exe, flush_if_id, freeze_all
  );

  modport slave (
    input  id_valid, src1, src2, two_src, id_dest, id_wb_en, id_mem_r_en,
           br_taken, mem_ready,
    output freeze_if_id, bubble_id_exe, flush_if_id, freeze_all
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Two-slot destination shadow (EXE, MEM) of the instructions ahead of ID.
//   clk, rst      : clock, synchronous active-high reset (empties both slots)
//   advance       : shift the pipeline shadow this edge (low while frozen)
//   issue         : ID instruction enters EXE; otherwise a bubble enters
//   id_dest/id_wb_en/id_mem_r_en : ID instruction's write-back info
//   src1, src2    : ID source registers to test
//   srcN_exe/mem  : srcN matches a pending write in EXE / MEM
//   exe_mem_r     : EXE holds a load (its result is not forwardable yet)
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       issue,
  input  logic [4:0] id_dest,
  input  logic       id_wb_en,
  input  logic       id_mem_r_en,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  output logic       src1_exe,
  output logic       src1_mem,
  output logic       src2_exe,
  output logic       src2_mem,
  output logic       exe_mem_r
);

  slot_t exe_q, exe_d;
  slot_t mem_q, mem_d;

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    if (advance) begin
      mem_d = exe_q;
      exe_d = issue ? slot_t'{v: 1'b1, dest: id_dest, wb_en: id_wb_en,
                              mem_r: id_mem_r_en}
                    : SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
    end
  end

  assign src1_exe  = slot_match(src1, exe_q.v, exe_q.wb_en, exe_q.dest);
  assign src1_mem  = slot_match(src1, mem_q.v, mem_q.wb_en, mem_q.dest);
  assign src2_exe  = slot_match(src2, exe_q.v, exe_q.wb_en, exe_q.dest);
  assign src2_mem  = slot_match(src2, mem_q.v, mem_q.wb_en, mem_q.dest);
  assign exe_mem_r = exe_q.mem_r;

  // A load in MEM has already produced its data for the forwarding path.
  logic unused_mem_r;
  assign unused_mem_r = mem_q.mem_r;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
//   clk, rst      : core clock, synchronous active-high reset
//   hif (slave)   : ID decode info in, freeze/bubble/flush controls out
//   state         : registered FSM state (RUN=0, STALL=1, FREEZE=2)
//   stall_cycles  : cycles with a bubble inserted into ID/EXE (saturating)
//   flush_count   : cycles with IF/ID flushed by a taken branch (saturating)
//   freeze_cycles : cycles with the whole pipeline frozen (saturating)
// FORWARD_EN=1 assumes a forwarding unit, so only load-use is a hazard.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.slave  hif,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    flush_count,
  output logic [CNT_W-1:0]    freeze_cycles
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic en);
    return (en && (c != '1)) ? c + 1'b1 : c;
  endfunction

  logic src1_exe, src1_mem, src2_exe, src2_mem, exe_mem_r;
  logic hit1, hit2, hazard, br, issue;
  logic freeze_if_id, bubble_id_exe, flush_if_id, freeze_all;

  hazard_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .advance     (~freeze_all),
    .issue       (issue),
    .id_dest     (hif.id_dest),
    .id_wb_en    (hif.id_wb_en),
    .id_mem_r_en (hif.id_mem_r_en),
    .src1        (hif.src1),
    .src2        (hif.src2),
    .src1_exe    (src1_exe),
    .src1_mem    (src1_mem),
    .src2_exe    (src2_exe),
    .src2_mem    (src2_mem),
    .exe_mem_r   (exe_mem_r)
  );

  // Without forwarding any pending write in EXE or MEM blocks the read;
  // WB is safe because the register file writes on the falling edge.
  assign hit1 = FORWARD_EN ? (src1_exe & exe_mem_r) : (src1_exe | src1_mem);
  assign hit2 = FORWARD_EN ? (src2_exe & exe_mem_r) : (src2_exe | src2_mem);

  assign hazard = hif.id_valid & (hit1 | (hif.two_src & hit2));
  // Branch operands that are still in flight make the decision unreliable.
  assign br     = hif.id_valid & hif.br_taken & ~hazard;
  assign issue  = hif.id_valid & ~hazard;

  // Priority: memory freeze, then data hazard, then taken branch.
  always_comb begin
    freeze_if_id  = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    freeze_all    = 1'b0;
    if (!rst) begin
      if (!hif.mem_ready) begin
        freeze_all   = 1'b1;
        freeze_if_id = 1'b1;
      end else if (hazard) begin
        freeze_if_id  = 1'b1;
        bubble_id_exe = 1'b1;
      end else if (br) begin
        flush_if_id = 1'b1;
      end
    end
  end

  assign hif.freeze_if_id  = freeze_if_id;
  assign hif.bubble_id_exe = bubble_id_exe;
  assign hif.flush_if_id   = flush_if_id;
  assign hif.freeze_all    = freeze_all;

  // Every state has the same exits, so the next state depends only on
  // this cycle's decision: freeze beats stall beats run.
  state_t state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN, STALL, FREEZE: begin
          if (!hif.mem_ready) state_q <= FREEZE;
          else if (hazard)    state_q <= STALL;
          else                state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign state = state_q;

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] frz_q, frz_d;

  always_comb begin
    stall_d = sat_inc(stall_q, bubble_id_exe);
    flush_d = sat_inc(flush_q, flush_if_id);
    frz_d   = sat_inc(frz_q, freeze_all);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      frz_q   <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      frz_q   <= frz_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign freeze_cycles = frz_q;

endmodule
